// File: rtl/sevenseg_demux.sv
// sevenseg_demux: receive side of a two-digit multiplexed seven-segment display.
// Samples the segment/digit-select lines, waits for each word to settle, and
// decodes every captured digit back to BCD. It also flags undecodable
// patterns and a scan that has stopped.
module sevenseg_demux #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cathod_anode,
    input  logic [6:0] seg_in,
    input  logic [1:0] an_in,
    output logic [3:0] units_bcd,
    output logic [3:0] tens_bcd,
    output logic       units_valid,
    output logic       tens_valid,
    output logic       pair_valid,
    output logic       seg_err,
    output logic       stale
);

    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]        CAP_AT    = 8'(STABLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    // Word layout: {cathod_anode, an[1:0], seg[6:0]}
    logic [9:0]        word_p0;   // first synchronizer flop (s1)
    logic [9:0]        word_p1;   // second synchronizer flop (s2)
    logic [7:0]        cnt;
    logic              cap_done;
    logic [1:0]        seen;      // [1] = units seen, [0] = tens seen
    logic [IDLE_W-1:0] idle;

    logic       ca_p1;
    logic [1:0] act_p1;
    logic [6:0] nseg_p1;
    logic [4:0] dec_p1;
    logic       dec_ok_p1;
    logic [3:0] dec_digit_p1;
    logic       one_hot_p1;
    logic       sel_units_p1;
    logic       cap_p1;
    logic [1:0] seen_set_p1;

    // Map a normalised (active-high) segment pattern to {ok, digit}.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'd0;
        case (s)
            7'h3F:   r = {1'b1, 4'd0};
            7'h06:   r = {1'b1, 4'd1};
            7'h5B:   r = {1'b1, 4'd2};
            7'h4F:   r = {1'b1, 4'd3};
            7'h66:   r = {1'b1, 4'd4};
            7'h6D:   r = {1'b1, 4'd5};
            7'h7D:   r = {1'b1, 4'd6};
            7'h07:   r = {1'b1, 4'd7};
            7'h7F:   r = {1'b1, 4'd8};
            7'h6F:   r = {1'b1, 4'd9};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    // Common-anode lines are active-low; fold them to active-high.
    function automatic logic [6:0] norm_seg(input logic ca, input logic [6:0] s);
        return ca ? ~s : s;
    endfunction

    function automatic logic [1:0] norm_an(input logic ca, input logic [1:0] a);
        return ca ? ~a : a;
    endfunction

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Two-flop synchronizer for the whole sampled word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_p0 <= '0;
            word_p1 <= '0;
        end else begin
            word_p0 <= {cathod_anode, an_in, seg_in};
            word_p1 <= word_p0;
        end
    end

    // Decode of the settled word held in the second flop.
    always_comb begin
        ca_p1        = word_p1[9];
        act_p1       = norm_an(ca_p1, word_p1[8:7]);
        nseg_p1      = norm_seg(ca_p1, word_p1[6:0]);
        dec_p1       = seg_decode(nseg_p1);
        dec_ok_p1    = dec_p1[4];
        dec_digit_p1 = dec_p1[3:0];
        one_hot_p1   = (act_p1 == 2'b01) || (act_p1 == 2'b10);
        sel_units_p1 = act_p1[1];
        // Capture fires on the edge after the word has been seen equal in
        // both flops STABLE_CYCLES-1 times; it may coincide with the next
        // word arriving in the first flop, which is why it does not check
        // word_p0 == word_p1 itself.
        cap_p1       = (cnt == CAP_AT) && !cap_done && one_hot_p1;
        seen_set_p1  = seen | (sel_units_p1 ? 2'b10 : 2'b01);
    end

    // Stability window: restart whenever the two flops disagree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 8'd0;
            cap_done <= 1'b0;
        end else if (word_p0 != word_p1) begin
            // A new word wins over a capture on the same edge so that the
            // new dwell is still allowed its own capture.
            cnt      <= 8'd0;
            cap_done <= 1'b0;
        end else begin
            cnt <= sat_inc8(cnt);
            if (cap_p1) begin
                cap_done <= 1'b1;
            end
        end
    end

    // Digit registers, pair tracking, error pulse and scan timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            units_bcd   <= 4'd0;
            tens_bcd    <= 4'd0;
            units_valid <= 1'b0;
            tens_valid  <= 1'b0;
            pair_valid  <= 1'b0;
            seg_err     <= 1'b0;
            stale       <= 1'b0;
            seen        <= 2'b00;
            idle        <= '0;
        end else begin
            pair_valid <= 1'b0;
            seg_err    <= 1'b0;
            if (cap_p1) begin
                // Any capture, good or bad, proves the scan is alive.
                idle  <= '0;
                stale <= 1'b0;
                if (dec_ok_p1) begin
                    if (sel_units_p1) begin
                        units_bcd   <= dec_digit_p1;
                        units_valid <= 1'b1;
                    end else begin
                        tens_bcd   <= dec_digit_p1;
                        tens_valid <= 1'b1;
                    end
                    if (seen_set_p1 == 2'b11) begin
                        pair_valid <= 1'b1;
                        seen       <= 2'b00;
                    end else begin
                        seen <= seen_set_p1;
                    end
                end else begin
                    // Keep the last good digit but mark it untrusted.
                    if (sel_units_p1) begin
                        units_valid <= 1'b0;
                    end else begin
                        tens_valid <= 1'b0;
                    end
                    seg_err <= 1'b1;
                    seen    <= 2'b00;
                end
            end else if (idle != IDLE_MAX) begin
                idle <= idle + 1'b1;
                if (idle == IDLE_LAST) begin
                    stale       <= 1'b1;
                    units_valid <= 1'b0;
                    tens_valid  <= 1'b0;
                    seen        <= 2'b00;
                end
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_demux.sv
// Bench for sevenseg_demux: drives word dwells, predicts each capture with a
// transaction-level model and checks the outputs on the predicted edge.
module tb_sevenseg_demux;

    localparam int STB = 4;
    localparam int TMO = 20;
    localparam logic [6:0] CC_TAB [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cathod_anode = 1'b1;
    logic [6:0] seg_in = 7'h7F;
    logic [1:0] an_in = 2'b11;
    logic [3:0] units_bcd, tens_bcd;
    logic       units_valid, tens_valid, pair_valid, seg_err, stale;

    sevenseg_demux #(.STABLE_CYCLES(STB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .cathod_anode(cathod_anode), .seg_in(seg_in),
        .an_in(an_in), .units_bcd(units_bcd), .tens_bcd(tens_bcd),
        .units_valid(units_valid), .tens_valid(tens_valid),
        .pair_valid(pair_valid), .seg_err(seg_err), .stale(stale)
    );

    always #5 clk = ~clk;

    // Edge index: first posedge after reset release is edge 0.
    int edge_n = -1;
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_n <= -1;
        else      edge_n <= edge_n + 1;
    end

    typedef struct {
        int          at_edge;
        logic [12:0] snap;
        string       tag;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int stray   = 0;
    int both    = 0;

    // Reference model state
    logic [3:0] m_ub, m_tb;
    logic       m_uv, m_tv, m_stale;
    logic [1:0] m_seen;
    int         m_last;

    function automatic logic [12:0] obs();
        return {units_bcd, tens_bcd, units_valid, tens_valid, pair_valid, seg_err, stale};
    endfunction

    function automatic logic [4:0] digit_of(input logic [6:0] ns);
        for (int d = 0; d < 10; d++) begin
            if (CC_TAB[d] == ns) return {1'b1, 4'(d)};
        end
        return 5'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ub = 4'd0; m_tb = 4'd0; m_uv = 1'b0; m_tv = 1'b0;
        m_stale = 1'b0; m_seen = 2'b00; m_last = -1;
    endtask

    // Apply the scan timeout if it has fired by edge e.
    task automatic advance(input int e);
        if (!m_stale && e >= m_last + TMO) begin
            m_stale = 1'b1; m_uv = 1'b0; m_tv = 1'b0; m_seen = 2'b00;
        end
    endtask

    task automatic push(input int e, input string tag, input logic pv, input logic se);
        exp_t it;
        it.at_edge = e;
        it.snap    = {m_ub, m_tb, m_uv, m_tv, pv, se, m_stale};
        it.tag     = tag;
        sb.push_back(it);
    endtask

    task automatic expect_at(input int e, input string tag);
        advance(e);
        push(e, tag, 1'b0, 1'b0);
    endtask

    // Drive a new word (called at a negedge) and predict the edge k+STB+1.
    task automatic start_word(input logic ca, input logic [1:0] an, input logic [6:0] seg,
                              input int n, input string tag);
        int         e;
        logic [1:0] act;
        logic [6:0] ns;
        logic [4:0] d;
        logic       pv, se;
        e  = edge_n + 1 + STB + 1;
        cathod_anode = ca; an_in = an; seg_in = seg;
        pv = 1'b0; se = 1'b0;
        act = ca ? ~an : an;
        ns  = ca ? ~seg : seg;
        if (n >= STB && (act == 2'b01 || act == 2'b10)) begin
            advance(e - 1);
            m_last = e; m_stale = 1'b0;
            d = digit_of(ns);
            if (d[4]) begin
                if (act[1]) begin m_ub = d[3:0]; m_uv = 1'b1; m_seen[1] = 1'b1; end
                else        begin m_tb = d[3:0]; m_tv = 1'b1; m_seen[0] = 1'b1; end
                if (m_seen == 2'b11) begin pv = 1'b1; m_seen = 2'b00; end
            end else begin
                if (act[1]) m_uv = 1'b0; else m_tv = 1'b0;
                se = 1'b1; m_seen = 2'b00;
            end
        end else begin
            advance(e);
        end
        push(e, tag, pv, se);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dwell(input logic ca, input logic [1:0] an, input logic [6:0] seg,
                         input int n, input string tag);
        start_word(ca, an, seg, n, tag);
        hold(n);
    endtask

    // Pops expectations on their edge; any pulse outside one is stray.
    task automatic monitor();
        exp_t it;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (sb.size() > 0 && sb[0].at_edge == edge_n) begin
                    while (sb.size() > 0 && sb[0].at_edge == edge_n) begin
                        it = sb.pop_front();
                        check(it.tag, {19'd0, obs()}, {19'd0, it.snap});
                    end
                end else if (pair_valid || seg_err) begin
                    stray++;
                end
                if (pair_valid && seg_err) both++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int c;
        model_reset();
        fork
            monitor();
        join_none

        hold(3);
        check("reset_state", {19'd0, obs()}, 32'd0);
        rst = 1'b1;

        // Common anode: units 3, then tens 1 completes the pair
        dwell(1'b1, 2'b01, ~CC_TAB[3], 6, "ca_units3");
        dwell(1'b1, 2'b10, ~CC_TAB[1], 6, "ca_tens1_pair");

        // Short glitch between stable words is ignored
        dwell(1'b1, 2'b01, ~CC_TAB[7], 6, "ca_units7");
        dwell(1'b1, 2'b01, ~CC_TAB[5], 3, "glitch_units5");
        dwell(1'b1, 2'b10, ~CC_TAB[2], 6, "ca_tens2_pair");

        // Blank slot (both lines inactive) lets the scan time out
        c = edge_n + 1;
        start_word(1'b1, 2'b11, 7'h7F, 25, "blank_ca");
        expect_at(c + TMO - 2, "pre_timeout");
        expect_at(c + TMO - 1, "timeout_stale");
        hold(25);
        dwell(1'b1, 2'b01, ~CC_TAB[9], 6, "stale_cleared");
        dwell(1'b1, 2'b10, ~CC_TAB[4], 6, "ca_tens4_pair");

        // Common cathode and polarity change on an otherwise identical word
        dwell(1'b0, 2'b10, CC_TAB[6], 6, "cc_units6");
        dwell(1'b0, 2'b10, 7'h06, 6, "cc_units1");
        dwell(1'b1, 2'b10, 7'h06, 6, "pol_flip_err");
        dwell(1'b0, 2'b10, 7'h49, 6, "cc_invalid");

        // Same digit twice does not complete a pair
        dwell(1'b0, 2'b10, CC_TAB[8], 6, "cc_units8");
        dwell(1'b0, 2'b10, CC_TAB[5], 6, "cc_units5_nopair");
        dwell(1'b0, 2'b01, CC_TAB[0], 6, "cc_tens0_pair");

        // Long hold captures once, then times out
        c = edge_n + 1 + STB + 1;
        start_word(1'b0, 2'b01, CC_TAB[3], 30, "long_hold_cap");
        expect_at(c + TMO, "long_hold_stale");
        hold(30);
        dwell(1'b0, 2'b10, CC_TAB[2], 7, "units2_pre_rst");

        // Reset part-way through a tens dwell
        check("sb_empty_pre_rst", sb.size(), 0);
        cathod_anode = 1'b0; an_in = 2'b01; seg_in = CC_TAB[7];
        hold(3);
        #2 rst = 1'b0;
        #1 check("rst_async", {19'd0, obs()}, 32'd0);
        model_reset();
        hold(2);
        rst = 1'b1;
        expect_at(STB + 1, "rst_no_cap");
        hold(2);
        dwell(1'b0, 2'b00, 7'h00, 3, "cc_blank");
        dwell(1'b0, 2'b01, CC_TAB[4], 6, "tens4_after_rst");
        dwell(1'b0, 2'b10, CC_TAB[9], 6, "pair_after_rst");

        hold(10);
        check("sb_drain", sb.size(), 0);
        check("stray_pulses", stray, 0);
        check("dual_pulse", both, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
